// File: rtl/fifo_wr_arbiter_if.sv
// Purpose: bundles the requester handshake, FIFO write pins and status of fifo_wr_arbiter.
// Latency: n/a (wires only).
// Backpressure: gnt_o is the per-requester ready; fifo_full_i stalls the granted requester.
// Ports: req_i/data_i/gnt_o (requesters), fifo_full_i/fifo_wr_error_i/fifo_wr_en_o/
//        fifo_wdata_o (FIFO write side), grant_id_o/busy_o/beat_cnt_o/ovf_err_o (status).
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4,
  parameter int IDW       = $clog2(NUM_REQ),
  parameter int BCW       = $clog2(MAX_BURST + 1)
);
  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*WIDTH-1:0] data_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic                     fifo_full_i;
  logic                     fifo_wr_error_i;
  logic                     fifo_wr_en_o;
  logic [WIDTH-1:0]         fifo_wdata_o;
  logic [IDW-1:0]           grant_id_o;
  logic                     busy_o;
  logic [BCW-1:0]           beat_cnt_o;
  logic                     ovf_err_o;

  // Environment side: requesters plus the FIFO flags.
  modport master (
    output req_i, data_i, fifo_full_i, fifo_wr_error_i,
    input  gnt_o, fifo_wr_en_o, fifo_wdata_o, grant_id_o, busy_o, beat_cnt_o, ovf_err_o
  );

  // Arbiter side.
  modport slave (
    input  req_i, data_i, fifo_full_i, fifo_wr_error_i,
    output gnt_o, fifo_wr_en_o, fifo_wdata_o, grant_id_o, busy_o, beat_cnt_o, ovf_err_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Purpose: round-robin arbiter sharing the FIFO write port among NUM_REQ requesters, bursts of up to MAX_BURST words.
// Latency: 1 cycle request->grant, 1 cycle accept->fifo_wr_en_o; one idle bubble between bursts.
// Backpressure: fifo_full_i drops gnt_o and freezes the burst; non-owner requests wait for their turn.
// Ports: wr_clk_i, rst_i (async, active-high), arb_if (slave modport of fifo_wr_arbiter_if).
module fifo_wr_arbiter #(
  parameter int  NUM_REQ   = 4,
  parameter int  WIDTH     = 16,
  parameter int  MAX_BURST = 4,
  localparam int IDW       = $clog2(NUM_REQ),
  localparam int BCW       = $clog2(MAX_BURST + 1)
) (
  input  logic             wr_clk_i,
  input  logic             rst_i,
  fifo_wr_arbiter_if.slave arb_if
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   last_owner_q, last_owner_d;
  logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
  logic             wr_en_q, wr_en_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             ovf_q, ovf_d;

  logic [IDW-1:0]   rr_pick, rr_cand;
  logic             rr_hit;
  logic [WIDTH-1:0] owner_dat;
  logic             owner_req;
  logic             accept;
  logic [BCW-1:0]   beat_inc;

  // Round-robin pick: first request scanning from last_owner+1 upwards with wrap.
  always_comb begin
    rr_pick = last_owner_q;
    rr_hit  = 1'b0;
    rr_cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_cand = IDW'((int'(last_owner_q) + i) % NUM_REQ);
      if (!rr_hit && arb_if.req_i[rr_cand]) begin
        rr_pick = rr_cand;
        rr_hit  = 1'b1;
      end
    end
  end

  // Owner's request and data slice, selected with constant indices.
  always_comb begin
    owner_dat = '0;
    owner_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_q == IDW'(k)) begin
        owner_dat = arb_if.data_i[k*WIDTH +: WIDTH];
        owner_req = arb_if.req_i[k];
      end
    end
  end

  assign accept   = (state_q == ST_BURST) && owner_req && !arb_if.fifo_full_i;
  assign beat_inc = beat_cnt_q + BCW'(1);

  always_comb begin
    arb_if.gnt_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_if.gnt_o[k] = (state_q == ST_BURST) && (owner_q == IDW'(k)) && !arb_if.fifo_full_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    wr_en_d      = 1'b0;
    wdata_d      = wdata_q;
    ovf_d        = ovf_q | arb_if.fifo_wr_error_i;

    case (state_q)
      ST_IDLE: begin
        if (|arb_if.req_i) begin
          owner_d    = rr_pick;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        if (accept) begin
          wr_en_d    = 1'b1;
          wdata_d    = owner_dat;
          beat_cnt_d = beat_inc;
          if (beat_inc == BCW'(MAX_BURST)) begin
            state_d      = ST_IDLE;
            last_owner_d = owner_q;
          end
        end else if (!owner_req) begin
          // Owner withdrew: end the burst early, rotation continues after it.
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
        end
        // Full with request still up: stall in place.
      end
    endcase
  end

  always_ff @(posedge wr_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= IDW'(NUM_REQ - 1);  // requester 0 wins first after reset
      beat_cnt_q   <= '0;
      wr_en_q      <= 1'b0;
      wdata_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_en_q      <= wr_en_d;
      wdata_q      <= wdata_d;
      ovf_q        <= ovf_d;
    end
  end

  assign arb_if.fifo_wr_en_o = wr_en_q;
  assign arb_if.fifo_wdata_o = wdata_q;
  assign arb_if.grant_id_o   = owner_q;
  assign arb_if.busy_o       = (state_q == ST_BURST);
  assign arb_if.beat_cnt_o   = beat_cnt_q;
  assign arb_if.ovf_err_o    = ovf_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write side of the dual-clock FIFO among `NUM_REQ` requesters in the write clock domain. It grants one requester at a time for a burst of up to `MAX_BURST` words and stalls the burst on FIFO full. Accepted words go to the FIFO through a one-stage output register. A sticky flag records any write error reported by the FIFO. The block sits directly in front of the FIFO's `wr_en_i`/`wdata_i`/`full_o`/`wr_error_o` pins.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `WIDTH`, default 16: data width; must equal the FIFO `WIDTH`.
- `MAX_BURST`, default 4: maximum words per grant, ≥1.
- `IDW` = `$clog2(NUM_REQ)`; `BCW` = `$clog2(MAX_BURST+1)` (derived).

Ports:
- `wr_clk_i`  in  1  write-domain clock; all logic is on its rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  `NUM_REQ`  per-requester valid; data is present when high.
- `data_i`  in  `NUM_REQ*WIDTH`  requester k's word is at `[k*WIDTH +: WIDTH]`.
- `gnt_o`  out  `NUM_REQ`  per-requester ready, combinational.
- `fifo_full_i`  in  1  FIFO `full_o`.
- `fifo_wr_error_i`  in  1  FIFO `wr_error_o`.
- `fifo_wr_en_o`  out  1  registered write enable to the FIFO.
- `fifo_wdata_o`  out  `WIDTH`  registered write data to the FIFO.
- `grant_id_o`  out  `IDW`  current owner index; valid while `busy_o` is high.
- `busy_o`  out  1  high in the BURST state.
- `beat_cnt_o`  out  `BCW`  words accepted in the current burst.
- `ovf_err_o`  out  1  sticky; set when `fifo_wr_error_i` is high.

## Operation
- **States:** IDLE and BURST. Internal registers: `owner`, `last_owner`, `beat_cnt`.
- **IDLE:**
  - If `req_i != 0`, select the first set bit scanning `last_owner+1`, `last_owner+2`, … modulo `NUM_REQ`.
  - Register it into `owner`, clear `beat_cnt`, go to BURST.
  - No data is accepted in IDLE.
- **BURST:**
  - `accept` = `req_i[owner] & ~fifo_full_i`.
  - `gnt_o[k]` = (state==BURST) & (k==owner) & `~fifo_full_i`.
  - Handshake: a word transfers on an edge where `req_i[k]` and `gnt_o[k]` are both high. Requesters must hold `data_i` stable while `req_i` is high and no grant has been given.
  - On accept: `fifo_wdata_o` ← owner's slice, `fifo_wr_en_o` ← 1, `beat_cnt` += 1.
  - Exit to IDLE with `last_owner` ← `owner` when either:
    - an accepted word brings `beat_cnt` to `MAX_BURST`, or
    - `req_i[owner]`==0 on a BURST cycle (the request dropped).
  - `fifo_full_i` high with `req_i[owner]` high: stall in BURST. `gnt_o` is low, the beat count is unchanged, and there is no exit.
- **Output register:** `fifo_wr_en_o` is 0 on every edge without an accept. `fifo_wdata_o` holds its last value when there is no accept.
- **Error flag:** `ovf_err_o` ← 1 on any edge where `fifo_wr_error_i`==1. Only reset clears it.
- **Other requesters:** non-owner requests are ignored during BURST. A requester that drops `req_i` before being granted is simply skipped.
- **Widths:** `beat_cnt` saturates at `MAX_BURST`, which is never exceeded. The round-robin index wraps from `NUM_REQ-1` to 0.

## Timing
- **Reset values:** state=IDLE, `last_owner`=`NUM_REQ-1` (so requester 0 wins first), `owner`=0, `beat_cnt`=0. Outputs: `fifo_wr_en_o`=0, `fifo_wdata_o`=0, `grant_id_o`=0, `busy_o`=0, `beat_cnt_o`=0, `ovf_err_o`=0, `gnt_o`=0.
- **Arbitration latency:** a request seen in IDLE at edge N gives `busy_o`/`gnt_o` high after edge N.
- **First write:** the first word is accepted at edge N+1 and `fifo_wr_en_o` is high after N+1. The FIFO captures the word at edge N+2.
- **Throughput:** one word per cycle within a burst. There is one idle bubble cycle between consecutive bursts.
- **Reset mid-burst:** all state clears immediately. An in-flight registered write is dropped because `fifo_wr_en_o` goes to 0. Arbitration restarts from requester 0.
- **Full flag lag:** `fifo_full_i` is sampled as-is. An overrun caused by flag latency is reported by the FIFO through `fifo_wr_error_i` and latched in `ovf_err_o`.

## Test plan
- **Single requester, burst limit:** Reset, then `req_i`=4'b0010 held, with `data_i` slice 1 = 0xA000+beat and `MAX_BURST`=4.
  - After 1 arbitration cycle, grant_id=1 and 4 consecutive writes 0xA000..0xA003 appear on `fifo_wr_en_o`/`fifo_wdata_o`.
  - Then 1 IDLE cycle, then regrant to 1.
- **Round-robin fairness:** `req_i`=4'b1111 held. Grant order is 0,1,2,3,0 with 4 words each and exactly 1 bubble cycle between bursts.
- **Early drop:** Requester 2 drops `req_i` after 2 accepted words. `beat_cnt_o`=2, then IDLE, and the next grant goes to the next pending requester after 2.
- **Full stall:** Hold `fifo_full_i`=1 for 3 cycles mid-burst. `gnt_o`=0, `fifo_wr_en_o`=0 and `beat_cnt_o` is frozen. The burst resumes with no word lost or duplicated.
- **Error and reset:** Pulse `fifo_wr_error_i` for 1 cycle, so `ovf_err_o`=1 and it stays set. Assert `rst_i` mid-burst: all outputs go to their reset values immediately, and the next grant goes to requester 0.
